instr_assembler: RTL and testbench
==================================

# instr_assembler

- Packs decoded instruction fields plus a 32-bit immediate into a 32-bit RV32I instruction word.
- Writes the packed words to consecutive instruction-memory addresses.
- Sits between the debug/boot loader front-end and the instruction-memory write port, so firmware can be streamed in as fields rather than raw words.
- Is the encoding counterpart of the core's immediate-extension stage, and uses the same ImmSrc type code.

## Interface
Parameters:
- ADDR_W, 8, word-address width of the instruction memory.
- BASE_ADDR, 0, first word address written after Start.

Ports:
- clk  in  1  system clock; one clock domain, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle pulse: clear counters and begin a new program.
- InValid  in  1  request valid.
- InReady  out  1  request accepted this cycle when InValid && InReady.
- ImmSrc  in  3  000 I, 001 S, 010 B, 011 U, 100 J; 101–111 illegal.
- Opcode  in  7  instruction bits [6:0].
- Rd, Rs1, Rs2  in  5 each  register fields.
- Funct3  in  3  function field.
- Funct7  in  7  carried for completeness; not encoded for any ImmSrc.
- Imm  in  32  immediate as a signed or unsigned byte value.
- Last  in  1  marks the final instruction of the program.
- MemWE  out  1  instruction-memory write strobe.
- MemAddr  out  ADDR_W  word write address.
- MemWData  out  32  packed instruction.
- Count  out  ADDR_W+1  number of words written since Start.
- Done  out  1  program written successfully.
- Error  out  1  sticky error flag.
- ErrCode  out  3  000 none, 001 range, 010 misaligned, 011 illegal ImmSrc, 100 address overflow.

## Operation
FSM states: IDLE, RUN, DONE, ERR.
- Start, from any state: go to RUN, pointer := BASE_ADDR, Count := 0, Error/ErrCode/Done := 0.
- InReady = (state == RUN) && !Start. Because of this, Start wins over a same-cycle handshake.
- Checks are made on each accepted request, highest priority first:
  - Illegal ImmSrc → 011.
  - B or J with Imm[0] = 1 → 010.
  - Range, by type:
    - I and S: Imm[31:11] all equal.
    - B: Imm[31:12] all equal.
    - J: Imm[31:20] all equal.
    - U: Imm[11:0] == 0.
    - Range failure → 001.
- On a failed check: no write, Count unchanged, go to ERR with Error = 1 and ErrCode set.
- On a passing check, pack the word as follows (always RV32I bit order):
  - I: {Imm[11:0], Rs1, Funct3, Rd, Opcode}.
  - S: {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}.
  - B: {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode}.
  - U: {Imm[31:12], Rd, Opcode}.
  - J: {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Opcode}.
- After a successful accept, the pointer and Count increment, then:
  - Last = 1 → go to DONE.
  - Else, if the word was written at the last address (all ones): go to ERR, ErrCode 100. The write itself still happens; the pointer does not wrap.
  - Otherwise stay in RUN.
- DONE and ERR hold until Start. Requests are never accepted in IDLE, DONE or ERR.
- Round-trip property: re-extending MemWData with the same ImmSrc returns Imm exactly, for every passing request.

## Timing
- Reset values:
  - state IDLE, pointer BASE_ADDR.
  - InReady, MemWE, Done, Error 0.
  - MemAddr BASE_ADDR, MemWData 0, Count 0, ErrCode 000.
- Latency: a request accepted at edge N gives MemWE = 1 with MemAddr/MemWData valid for exactly the cycle after N (registered outputs).
- Throughput: one word per cycle with InValid held high.
- Done and Error are registered from the accept edge, so each rises in the same cycle as the final MemWE or the suppressed write.
- Start during RUN drops nothing already accepted: the pending MemWE for the previous accept still completes in the next cycle.
- rst_n asserted mid-program: all outputs reset immediately, asynchronously, and any pending write is discarded.

## Structure
- Shared package holds:
  - IMM_I/S/B/U/J localparams for the ImmSrc codes, shared with the immediate-extension stage.
  - ERR_* codes.
  - FSM state encoding.
- One sub-module is natural: instr_packer, purely combinational, fields + ImmSrc → {word, err_code}. The FSM, pointer and output registers stay in instr_assembler.

## Test plan
- I-type: Opcode 0010011, Rd 1, Rs1 2, Funct3 0, Imm −1 → next cycle MemWE = 1, MemAddr 0, MemWData 0xFFF10093.
- Four mixed S/B/U/J requests back-to-back, last with Last = 1 → MemWE high for 4 cycles at addresses 0–3, each word re-extends to its Imm, Done = 1, Count = 4.
- Out-of-range and misaligned immediates:
  - B with Imm 0x1001 → Error = 1, ErrCode 010, no MemWE.
  - I with Imm 2048 after a Start → ErrCode 001.
- ImmSrc 101 → ErrCode 011, and InReady is 0 from the next cycle.
- Overflow: ADDR_W = 2, five requests without Last:
  - four writes at addresses 0–3, then ErrCode 100, Count = 4.
  - the fifth request is never accepted.
- Start pulsed with InValid = 1 in RUN, and rst_n pulsed mid-stream:
  - the Start-cycle request is not accepted, and Count restarts at 0.
  - on rst_n, all outputs are at reset values before the next clock edge.

Source files
------------

// File: rtl/instr_assembler_pkg.sv
// Shared definitions for the instruction assembler.
// Holds the ImmSrc type codes (identical to the immediate-extension stage),
// the ErrCode values reported by the assembler, the FSM state encoding and
// a small helper used by the immediate range checks.
package instr_assembler_pkg;

  // ImmSrc codes, shared with the immediate-extension stage
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // ErrCode values
  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_RANGE    = 3'b001;
  localparam logic [2:0] ERR_MISALIGN = 3'b010;
  localparam logic [2:0] ERR_ILLEGAL  = 3'b011;
  localparam logic [2:0] ERR_OVERFLOW = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // True when bits [31:lsb] of v are all equal, i.e. v is a correctly
  // sign-extended value of (lsb+1) bits.
  function automatic logic upper_uniform(input logic [31:0] v, input int lsb);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (b >= lsb && v[b] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_assembler_packer.sv
// Combinational field packer.
// Turns decoded fields plus a 32-bit immediate into an RV32I instruction
// word and reports whether the immediate can be encoded for the given type.
// Ports:
//   imm_src_i  instruction format (I/S/B/U/J code)
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i  register/function fields
//   imm_i      immediate value to encode
//   word_o     packed instruction (don't-care when err_code_o != ERR_NONE)
//   err_code_o ERR_NONE, or the highest-priority check that failed
module instr_packer
  import instr_assembler_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic [2:0]  err_code_o
);

  logic legal;
  logic aligned;
  logic range_ok;

  always_comb begin
    word_o   = '0;
    legal    = 1'b1;
    aligned  = 1'b1;
    range_ok = 1'b0;
    case (imm_src_i)
      IMM_I: begin
        word_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_ok = upper_uniform(imm_i, 11);
      end
      IMM_S: begin
        word_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_ok = upper_uniform(imm_i, 11);
      end
      IMM_B: begin
        word_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                    imm_i[4:1], imm_i[11], opcode_i};
        aligned  = ~imm_i[0];
        range_ok = upper_uniform(imm_i, 12);
      end
      IMM_U: begin
        word_o   = {imm_i[31:12], rd_i, opcode_i};
        // the low 12 bits cannot be represented in a U-type word
        range_ok = (imm_i[11:0] == 12'd0);
      end
      IMM_J: begin
        word_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        aligned  = ~imm_i[0];
        range_ok = upper_uniform(imm_i, 20);
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    // priority: illegal type, then alignment, then range
    if (!legal) begin
      err_code_o = ERR_ILLEGAL;
    end else if (!aligned) begin
      err_code_o = ERR_MISALIGN;
    end else if (!range_ok) begin
      err_code_o = ERR_RANGE;
    end else begin
      err_code_o = ERR_NONE;
    end
  end

endmodule

// File: rtl/instr_assembler.sv
// Instruction assembler.
// Accepts decoded instruction fields one request per cycle, packs them into
// RV32I words and writes them to consecutive instruction-memory addresses.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   Start             pulse: restart counters and begin a new program
//   InValid/InReady   request handshake
//   ImmSrc..Imm, Last request fields (Funct7 is carried but never encoded)
//   MemWE/MemAddr/MemWData  registered instruction-memory write port
//   Count             words written since Start
//   Done, Error, ErrCode    program status (Error/ErrCode sticky until Start)
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        ImmSrc,
  input  logic [6:0]        Opcode,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [2:0]        Funct3,
  input  logic [6:0]        Funct7,
  input  logic [31:0]       Imm,
  input  logic              Last,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic [ADDR_W:0]   Count,
  output logic              Done,
  output logic              Error,
  output logic [2:0]        ErrCode
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [2:0]        err_code_q, err_code_d;

  logic [31:0]       pack_word;
  logic [2:0]        pack_err;
  logic              in_ready;
  logic              accept;

  // Funct7 has no slot in any supported format
  logic              unused_funct7;
  assign unused_funct7 = ^Funct7;

  instr_packer u_packer (
    .imm_src_i  (ImmSrc),
    .opcode_i   (Opcode),
    .rd_i       (Rd),
    .rs1_i      (Rs1),
    .rs2_i      (Rs2),
    .funct3_i   (Funct3),
    .imm_i      (Imm),
    .word_o     (pack_word),
    .err_code_o (pack_err)
  );

  // Start takes precedence over a same-cycle handshake
  assign in_ready = (state_q == ST_RUN) && !Start;
  assign accept   = InValid && in_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;

    if (Start) begin
      state_d    = ST_RUN;
      ptr_d      = BASE_PTR;
      count_d    = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = ERR_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (pack_err != ERR_NONE) begin
              // rejected request: nothing is written
              state_d    = ST_ERR;
              error_d    = 1'b1;
              err_code_d = pack_err;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = pack_word;
              count_d = count_q + 1'b1;
              if (Last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                ptr_d   = ptr_q + 1'b1;
              end else if (ptr_q == '1) begin
                // last address just used: stop rather than wrap onto
                // words written earlier in this program
                state_d    = ST_ERR;
                error_d    = 1'b1;
                err_code_d = ERR_OVERFLOW;
              end else begin
                ptr_d = ptr_q + 1'b1;
              end
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR wait for Start
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= BASE_PTR;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_PTR;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign InReady  = in_ready;
  assign MemWE    = we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign Count    = count_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign ErrCode  = err_code_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Randomized bench for instr_assembler with a behavioural reference model.
module tb_instr_assembler;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        InValid;
  logic        InValid_s;
  logic [2:0]  ImmSrc;
  logic [6:0]  Opcode;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] Imm;
  logic        Last;

  logic        InReady, MemWE, Done, Error;
  logic [7:0]  MemAddr;
  logic [31:0] MemWData;
  logic [8:0]  Count;
  logic [2:0]  ErrCode;

  logic        InReady_s, MemWE_s, Done_s, Error_s;
  logic [1:0]  MemAddr_s;
  logic [31:0] MemWData_s;
  logic [2:0]  Count_s;
  logic [2:0]  ErrCode_s;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          m_running, m_done, m_err;
  int          m_code, m_ptr, m_count;
  bit          exp_we;
  int          exp_addr;
  logic [31:0] exp_word;

  instr_assembler dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .Funct3(Funct3), .Funct7(Funct7), .Imm(Imm), .Last(Last),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData), .Count(Count),
    .Done(Done), .Error(Error), .ErrCode(ErrCode)
  );

  instr_assembler #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .Start(Start), .InValid(InValid_s), .InReady(InReady_s),
    .ImmSrc(ImmSrc), .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .Funct3(Funct3), .Funct7(Funct7), .Imm(Imm), .Last(Last),
    .MemWE(MemWE_s), .MemAddr(MemAddr_s), .MemWData(MemWData_s), .Count(Count_s),
    .Done(Done_s), .Error(Error_s), .ErrCode(ErrCode_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Encoding computed by placing each immediate slice with shifts and masks
  function automatic logic [31:0] ref_pack(input logic [2:0] src, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (32'(Funct3) << 12) | 32'(Opcode);
    case (src)
      3'd0: return ((imm & 32'hFFF) << 20) | (32'(Rs1) << 15) | (32'(Rd) << 7) | regs;
      3'd1: return (((imm >> 5) & 32'h7F) << 25) | (32'(Rs2) << 20) | (32'(Rs1) << 15)
                   | ((imm & 32'h1F) << 7) | regs;
      3'd2: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                   | (32'(Rs2) << 20) | (32'(Rs1) << 15)
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | regs;
      3'd3: return (imm & 32'hFFFFF000) | (32'(Rd) << 7) | 32'(Opcode);
      default: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (32'(Rd) << 7) | 32'(Opcode);
    endcase
  endfunction

  // Immediate extension as the core's decoder would do it
  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] src);
    case (src)
      3'd0: return {{20{w[31]}}, w[31:20]};
      3'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3: return {w[31:12], 12'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic int ref_err(input logic [2:0] src, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    if (src > 3'd4) return 3;
    if ((src == 3'd2 || src == 3'd4) && (imm & 32'h1) != 0) return 2;
    case (src)
      3'd0, 3'd1: if (s < -2048 || s > 2047) return 1;
      3'd2:       if (s < -4096 || s > 4095) return 1;
      3'd3:       if ((imm & 32'hFFF) != 0) return 1;
      default:    if (s < -1048576 || s > 1048575) return 1;
    endcase
    return 0;
  endfunction

  task automatic set_req(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [31:0] imm, input logic last);
    ImmSrc = src; Opcode = op; Rd = rd; Rs1 = rs1; Rs2 = rs2; Funct3 = f3;
    Funct7 = 7'($urandom); Imm = imm; Last = last;
  endtask

  task automatic model_reset();
    m_running = 0; m_done = 0; m_err = 0; m_code = 0; m_ptr = 0; m_count = 0; exp_we = 0;
  endtask

  // One clock cycle on the main instance: drive, predict, check.
  task automatic step(input logic start, input logic valid);
    int e;
    bit acc;
    Start = start; InValid = valid;
    #1;
    check("in_ready", 32'(InReady), 32'(m_running && !start));
    acc = valid && m_running && !start;
    exp_we = 0;
    if (start) begin
      m_running = 1; m_done = 0; m_err = 0; m_code = 0; m_ptr = 0; m_count = 0;
    end else if (acc) begin
      e = ref_err(ImmSrc, Imm);
      if (e != 0) begin
        m_running = 0; m_err = 1; m_code = e;
      end else begin
        exp_we = 1; exp_addr = m_ptr; exp_word = ref_pack(ImmSrc, Imm);
        m_count++;
        if (Last) begin
          m_running = 0; m_done = 1;
        end else if (m_ptr == DEPTH - 1) begin
          m_running = 0; m_err = 1; m_code = 4;
        end else begin
          m_ptr++;
        end
      end
    end
    @(posedge clk); #1;
    Start = 0; InValid = 0;
    check("mem_we", 32'(MemWE), 32'(exp_we));
    if (exp_we) begin
      check("mem_addr", 32'(MemAddr), 32'(exp_addr));
      check("mem_wdata", MemWData, exp_word);
      check("round_trip", ref_ext(MemWData, ImmSrc), Imm);
    end
    check("count", 32'(Count), 32'(m_count));
    check("done", 32'(Done), 32'(m_done));
    check("error", 32'(Error), 32'(m_err));
    check("err_code", 32'(ErrCode), 32'(m_code));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(InReady), 0);
    check({tag, "_mem_we"}, 32'(MemWE), 0);
    check({tag, "_mem_addr"}, 32'(MemAddr), 0);
    check({tag, "_mem_wdata"}, MemWData, 0);
    check({tag, "_count"}, 32'(Count), 0);
    check({tag, "_done"}, 32'(Done), 0);
    check({tag, "_error"}, 32'(Error), 0);
    check({tag, "_err_code"}, 32'(ErrCode), 0);
  endtask

  task automatic rand_fields();
    logic [2:0] src;
    logic [31:0] imm;
    src = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    case (src)
      3'd0, 3'd1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd2:       imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      3'd3:       imm = $urandom & 32'hFFFFF000;
      default:    imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
    endcase
    if ($urandom_range(0, 7) == 0) imm = $urandom;
    set_req(src, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
            imm, $urandom_range(0, 9) == 0);
  endtask

  initial begin
    rst_n = 0; Start = 0; InValid = 0; InValid_s = 0;
    set_req(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b0);
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1;

    // IDLE never accepts
    step(1'b0, 1'b1);

    // I-type example
    step(1'b1, 1'b0);
    set_req(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFFFFFF, 1'b0);
    step(1'b0, 1'b1);
    check("i_type_word", MemWData, 32'hFFF10093);

    // mixed S/B/U/J back-to-back, last one ends the program
    step(1'b1, 1'b0);
    set_req(3'd1, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFFFFFB, 1'b0); step(1'b0, 1'b1);
    set_req(3'd2, 7'h63, 5'd0, 5'd5, 5'd6, 3'd1, 32'd2046, 1'b0);     step(1'b0, 1'b1);
    set_req(3'd3, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'hABCDE000, 1'b0); step(1'b0, 1'b1);
    set_req(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 1'b1); step(1'b0, 1'b1);
    check("mixed_done", 32'(Done), 1);
    check("mixed_count", 32'(Count), 4);
    step(1'b0, 1'b1);

    // misaligned branch, out-of-range I, illegal ImmSrc
    step(1'b1, 1'b0);
    set_req(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h00001001, 1'b0); step(1'b0, 1'b1);
    check("b_misalign_code", 32'(ErrCode), 2);
    step(1'b1, 1'b0);
    set_req(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048, 1'b0);     step(1'b0, 1'b1);
    check("i_range_code", 32'(ErrCode), 1);
    step(1'b1, 1'b0);
    set_req(3'd5, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd0, 1'b0);        step(1'b0, 1'b1);
    check("illegal_code", 32'(ErrCode), 3);
    step(1'b0, 1'b1);

    // overflow on the 4-word instance
    step(1'b1, 1'b0);
    set_req(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'd7, 1'b0);
    InValid_s = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("ovf_in_ready", 32'(InReady_s), 32'(k < 4));
      @(posedge clk); #1;
      check("ovf_mem_we", 32'(MemWE_s), 32'(k < 4));
      if (k < 4) check("ovf_mem_addr", 32'(MemAddr_s), 32'(k));
      if (k >= 3) begin
        check("ovf_error", 32'(Error_s), 1);
        check("ovf_err_code", 32'(ErrCode_s), 4);
        check("ovf_count", 32'(Count_s), 4);
      end
      // keep the main model in step: its InValid stays low
      check("ovf_main_we", 32'(MemWE), 0);
    end
    InValid_s = 0;
    #0;

    // Start with InValid high in RUN
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // asynchronous reset with a write pending
    step(1'b0, 1'b1);
    rst_n = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();

    // randomized stream
    for (int n = 0; n < 400; n++) begin
      logic st;
      rand_fields();
      st = m_running ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 0);
      step(st, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
